// File: rtl/multi_rect_pkg.sv
// Shared constants and helpers for the multi-rectangle draw stage.
// Border ring support is selected by MULTI_RECT_BORDER_EN in the consuming files.
package multi_rect_pkg;

  localparam int POS_W   = 12;
  localparam int ARITH_W = 14;
  localparam logic [23:0] BORDER_RGB = 24'hFFFFFF;

  function automatic logic [23:0] paletteColour(input int idx);
    case (idx)
      0:       paletteColour = 24'hFF0000;
      1:       paletteColour = 24'h00FF00;
      2:       paletteColour = 24'h0000FF;
      3:       paletteColour = 24'hFFFF00;
      4:       paletteColour = 24'hFF00FF;
      5:       paletteColour = 24'h00FFFF;
      6:       paletteColour = 24'hFF8000;
      default: paletteColour = 24'h8080FF;
    endcase
  endfunction

  // Signed sum is pinned into [0, maxV]; values in range keep their low bits.
  function automatic logic [POS_W-1:0] clampPos(input logic signed [ARITH_W-1:0] v,
                                                input logic [POS_W-1:0] maxV);
    if (v < 0)
      clampPos = '0;
    else if (v > $signed({{(ARITH_W-POS_W){1'b0}}, maxV}))
      clampPos = maxV;
    else
      clampPos = v[POS_W-1:0];
  endfunction

  function automatic logic signed [ARITH_W-1:0] stepDelta(input logic plus, input logic minus,
                                                          input int step);
    stepDelta = (plus ? ARITH_W'(step) : '0) - (minus ? ARITH_W'(step) : '0);
  endfunction

endpackage

// File: rtl/multi_rect_draw_rect_hit.sv
// Combinational hit test of the current pixel against one rectangle.
// With MULTI_RECT_BORDER_EN an extra flag marks the 2-px ring just inside the edge.
module rect_hit
  import multi_rect_pkg::*;
#(
  parameter int RECT_W = 64,
  parameter int RECT_H = 64
) (
  input  logic [POS_W-1:0] hcnt_i,
  input  logic [POS_W-1:0] vcnt_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  output logic             hit_o
`ifdef MULTI_RECT_BORDER_EN
  , output logic           edge_o
`endif
);

  localparam logic [POS_W:0] W_EXT = (POS_W+1)'(RECT_W);
  localparam logic [POS_W:0] H_EXT = (POS_W+1)'(RECT_H);

  logic [POS_W:0] hExt, vExt, xBeg, yBeg, xEnd, yEnd;
  logic inX, inY;

  assign hExt = {1'b0, hcnt_i};
  assign vExt = {1'b0, vcnt_i};
  assign xBeg = {1'b0, x_i};
  assign yBeg = {1'b0, y_i};
  assign xEnd = xBeg + W_EXT;
  assign yEnd = yBeg + H_EXT;
  assign inX  = (hExt >= xBeg) && (hExt < xEnd);
  assign inY  = (vExt >= yBeg) && (vExt < yEnd);
  assign hit_o = inX && inY;

`ifdef MULTI_RECT_BORDER_EN
  logic nearX, nearY;
  assign nearX  = (hExt < xBeg + (POS_W+1)'(2)) || (hExt >= xEnd - (POS_W+1)'(2));
  assign nearY  = (vExt < yBeg + (POS_W+1)'(2)) || (vExt >= yEnd - (POS_W+1)'(2));
  assign edge_o = hit_o && (nearX || nearY);
`endif

endmodule

// File: rtl/multi_rect_draw.sv
// Draws N movable rectangles over a background with a 2-clock sync/pixel pipeline.
// Define MULTI_RECT_BORDER_EN to ring the selected rectangle in white.
module multi_rect_draw
  import multi_rect_pkg::*;
#(
  parameter int          N_RECT = 4,
  parameter int          RECT_W = 64,
  parameter int          RECT_H = 64,
  parameter int          H_ACT  = 1280,
  parameter int          V_ACT  = 720,
  parameter int          STEP   = 8,
  parameter logic [23:0] BG_RGB = 24'h000000,
  localparam int         SEL_W  = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pls_c,
  input  logic             i_pls_e,
  input  logic             i_pls_w,
  input  logic             i_pls_s,
  input  logic             i_pls_n,
  input  logic             i_mouse_valid,
  input  logic [8:0]       i_mouse_dif_x,
  input  logic [8:0]       i_mouse_dif_y,
  input  logic             i_sync_vs,
  input  logic             i_sync_hs,
  input  logic             i_sync_va,
  input  logic             i_sync_ha,
  input  logic             i_sync_de,
  output logic             o_sync_vs,
  output logic             o_sync_hs,
  output logic             o_sync_va,
  output logic             o_sync_ha,
  output logic             o_sync_de,
  output logic [7:0]       o_sync_red,
  output logic [7:0]       o_sync_grn,
  output logic [7:0]       o_sync_blu,
  output logic [SEL_W-1:0] o_sel
);

  localparam logic [POS_W-1:0] X_MAX   = POS_W'(H_ACT - RECT_W);
  localparam logic [POS_W-1:0] Y_MAX   = POS_W'(V_ACT - RECT_H);
  localparam logic [POS_W-1:0] RESET_Y = POS_W'(16);

  function automatic logic [POS_W-1:0] resetX(input int k);
    int v;
    v = k * (RECT_W + 16);
    if (v > H_ACT - RECT_W) v = H_ACT - RECT_W;
    return POS_W'(v);
  endfunction

  logic [POS_W-1:0] liveX_q [N_RECT];
  logic [POS_W-1:0] liveY_q [N_RECT];
  logic [POS_W-1:0] liveX_d [N_RECT];
  logic [POS_W-1:0] liveY_d [N_RECT];
  logic [POS_W-1:0] shadowX_q [N_RECT];
  logic [POS_W-1:0] shadowY_q [N_RECT];
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vsPrev_q, haPrev_q, vsRise, btnAny;
  logic [POS_W-1:0] hcnt_q, vcnt_q;
  logic signed [ARITH_W-1:0] dx, dy, sumX, sumY;
  logic [N_RECT-1:0] hitComb, hit_q;
  logic [4:0]       sync1_q, sync2_q;
  logic [23:0]      pixelRgb, rgb_q;
`ifdef MULTI_RECT_BORDER_EN
  logic [SEL_W-1:0]  shadowSel_q;
  logic [N_RECT-1:0] edgeComb;
  logic              edge_q;
`endif

  assign vsRise = i_sync_vs & ~vsPrev_q;
  assign btnAny = i_pls_e | i_pls_w | i_pls_s | i_pls_n;

  // Buttons win over the mouse; the move lands on the selection held this cycle.
  always_comb begin
    liveX_d = liveX_q;
    liveY_d = liveY_q;
    sel_d   = sel_q;
    dx      = '0;
    dy      = '0;
    if (btnAny) begin
      dx = stepDelta(i_pls_e, i_pls_w, STEP);
      dy = stepDelta(i_pls_s, i_pls_n, STEP);
    end else if (i_mouse_valid) begin
      dx = {{(ARITH_W-9){i_mouse_dif_x[8]}}, i_mouse_dif_x};
      dy = {{(ARITH_W-9){i_mouse_dif_y[8]}}, i_mouse_dif_y};
    end
    sumX = $signed({{(ARITH_W-POS_W){1'b0}}, liveX_q[sel_q]}) + dx;
    sumY = $signed({{(ARITH_W-POS_W){1'b0}}, liveY_q[sel_q]}) + dy;
    liveX_d[sel_q] = clampPos(sumX, X_MAX);
    liveY_d[sel_q] = clampPos(sumY, Y_MAX);
    if (i_pls_c)
      sel_d = (sel_q == SEL_W'(N_RECT - 1)) ? '0 : sel_q + SEL_W'(1);
  end

  // Shadow copies are only refreshed at vsync so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_RECT; k++) begin
        liveX_q[k]   <= resetX(k);
        liveY_q[k]   <= RESET_Y;
        shadowX_q[k] <= resetX(k);
        shadowY_q[k] <= RESET_Y;
      end
      sel_q    <= '0;
      vsPrev_q <= 1'b0;
`ifdef MULTI_RECT_BORDER_EN
      shadowSel_q <= '0;
`endif
    end else begin
      liveX_q  <= liveX_d;
      liveY_q  <= liveY_d;
      sel_q    <= sel_d;
      vsPrev_q <= i_sync_vs;
      if (vsRise) begin
        shadowX_q <= liveX_q;
        shadowY_q <= liveY_q;
`ifdef MULTI_RECT_BORDER_EN
        shadowSel_q <= sel_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      haPrev_q <= 1'b0;
    end else begin
      haPrev_q <= i_sync_ha;
      hcnt_q   <= i_sync_ha ? hcnt_q + POS_W'(1) : '0;
      if (!i_sync_va)
        vcnt_q <= '0;
      else if (haPrev_q && !i_sync_ha)
        vcnt_q <= vcnt_q + POS_W'(1);
    end
  end

  for (genvar k = 0; k < N_RECT; k++) begin : g_hit
    rect_hit #(.RECT_W(RECT_W), .RECT_H(RECT_H)) u_hit (
      .hcnt_i (hcnt_q),
      .vcnt_i (vcnt_q),
      .x_i    (shadowX_q[k]),
      .y_i    (shadowY_q[k]),
      .hit_o  (hitComb[k])
`ifdef MULTI_RECT_BORDER_EN
      , .edge_o (edgeComb[k])
`endif
    );
  end

  // Walking downwards lets the lowest-index hit overwrite the others.
  always_comb begin
    pixelRgb = BG_RGB;
    for (int k = N_RECT - 1; k >= 0; k--)
      if (hit_q[k]) pixelRgb = paletteColour(k);
`ifdef MULTI_RECT_BORDER_EN
    if (edge_q) pixelRgb = BORDER_RGB;
`endif
    if (!sync1_q[0]) pixelRgb = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hit_q   <= '0;
      rgb_q   <= '0;
`ifdef MULTI_RECT_BORDER_EN
      edge_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= {i_sync_vs, i_sync_hs, i_sync_va, i_sync_ha, i_sync_de};
      hit_q   <= hitComb;
      sync2_q <= sync1_q;
      rgb_q   <= pixelRgb;
`ifdef MULTI_RECT_BORDER_EN
      edge_q  <= edgeComb[shadowSel_q];
`endif
    end
  end

  assign o_sync_vs  = sync2_q[4];
  assign o_sync_hs  = sync2_q[3];
  assign o_sync_va  = sync2_q[2];
  assign o_sync_ha  = sync2_q[1];
  assign o_sync_de  = sync2_q[0];
  assign o_sync_red = rgb_q[23:16];
  assign o_sync_grn = rgb_q[15:8];
  assign o_sync_blu = rgb_q[7:0];
  assign o_sel      = sel_q;

endmodule

// File: tb/tb_multi_rect_draw.sv
// Self-checking bench for multi_rect_draw: reference model plus scoreboard queue.
// Honours MULTI_RECT_BORDER_EN the same way as the design.
module tb_multi_rect_draw;

  localparam int NR = 4;
  localparam int RW = 64;
  localparam int RH = 64;
  localparam int XMAX = 1216;
  localparam int YMAX = 656;
  localparam int STEP = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic i_pls_c, i_pls_e, i_pls_w, i_pls_s, i_pls_n, i_mouse_valid;
  logic [8:0] i_mouse_dif_x, i_mouse_dif_y;
  logic i_sync_vs, i_sync_hs, i_sync_va, i_sync_ha, i_sync_de;
  logic o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de;
  logic [7:0] o_sync_red, o_sync_grn, o_sync_blu;
  logic [1:0] o_sel;

  multi_rect_draw dut (
    .clk(clk), .rst_n(rst_n),
    .i_pls_c(i_pls_c), .i_pls_e(i_pls_e), .i_pls_w(i_pls_w), .i_pls_s(i_pls_s), .i_pls_n(i_pls_n),
    .i_mouse_valid(i_mouse_valid), .i_mouse_dif_x(i_mouse_dif_x), .i_mouse_dif_y(i_mouse_dif_y),
    .i_sync_vs(i_sync_vs), .i_sync_hs(i_sync_hs), .i_sync_va(i_sync_va),
    .i_sync_ha(i_sync_ha), .i_sync_de(i_sync_de),
    .o_sync_vs(o_sync_vs), .o_sync_hs(o_sync_hs), .o_sync_va(o_sync_va),
    .o_sync_ha(o_sync_ha), .o_sync_de(o_sync_de),
    .o_sync_red(o_sync_red), .o_sync_grn(o_sync_grn), .o_sync_blu(o_sync_blu),
    .o_sel(o_sel)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] sync; logic [23:0] rgb; } exp_t;
  typedef struct { logic c, e, w, s, n, mv; logic [8:0] dx, dy; logic [1:0] expSel; } vec_t;

  exp_t expQ[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int mX[NR], mY[NR], sX[NR], sY[NR];
  int mSel, sSel;
  logic mPrevVs;
  int curPix, curLine;

  function automatic logic [23:0] pal(int k);
    case (k)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  function automatic int clampI(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [23:0] expColour(int p, int ln);
    logic [23:0] c;
    c = 24'h000000;
    for (int k = NR - 1; k >= 0; k--)
      if (p >= sX[k] && p < sX[k] + RW && ln >= sY[k] && ln < sY[k] + RH) c = pal(k);
`ifdef MULTI_RECT_BORDER_EN
    if (p >= sX[sSel] && p < sX[sSel] + RW && ln >= sY[sSel] && ln < sY[sSel] + RH &&
        (p < sX[sSel] + 2 || p >= sX[sSel] + RW - 2 || ln < sY[sSel] + 2 || ln >= sY[sSel] + RH - 2))
      c = 24'hFFFFFF;
`endif
    return c;
  endfunction

  function automatic vec_t mkVec(logic c, logic e, logic w, logic s, logic n, logic mv,
                                 logic [8:0] dx, logic [8:0] dy, logic [1:0] sel);
    vec_t v;
    v.c = c; v.e = e; v.w = w; v.s = s; v.n = n; v.mv = mv;
    v.dx = dx; v.dy = dy; v.expSel = sel;
    return v;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < NR; k++) begin
      mX[k] = (k * (RW + 16) > XMAX) ? XMAX : k * (RW + 16);
      mY[k] = 16;
      sX[k] = mX[k];
      sY[k] = mY[k];
    end
    mSel = 0; sSel = 0; mPrevVs = 1'b0;
    expQ.delete();
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clearPulses();
    i_pls_c = 0; i_pls_e = 0; i_pls_w = 0; i_pls_s = 0; i_pls_n = 0;
    i_mouse_valid = 0; i_mouse_dif_x = '0; i_mouse_dif_y = '0;
  endtask

  task automatic setSync(logic vs, logic hs, logic va, logic ha, logic de);
    i_sync_vs = vs; i_sync_hs = hs; i_sync_va = va; i_sync_ha = ha; i_sync_de = de;
  endtask

  // One clock: record expectation, advance the model, then score the output two cycles old.
  task automatic applyStimulus();
    exp_t e;
    int dx, dy;
    e.sync = {i_sync_vs, i_sync_hs, i_sync_va, i_sync_ha, i_sync_de};
    e.rgb  = i_sync_de ? expColour(curPix, curLine) : 24'h0;
    expQ.push_back(e);
    if (i_sync_vs && !mPrevVs) begin
      sX = mX; sY = mY; sSel = mSel;
    end
    mPrevVs = i_sync_vs;
    dx = 0; dy = 0;
    if (i_pls_e || i_pls_w || i_pls_s || i_pls_n) begin
      dx = (i_pls_e ? STEP : 0) - (i_pls_w ? STEP : 0);
      dy = (i_pls_s ? STEP : 0) - (i_pls_n ? STEP : 0);
    end else if (i_mouse_valid) begin
      dx = int'($signed(i_mouse_dif_x));
      dy = int'($signed(i_mouse_dif_y));
    end
    mX[mSel] = clampI(mX[mSel] + dx, XMAX);
    mY[mSel] = clampI(mY[mSel] + dy, YMAX);
    if (i_pls_c) mSel = (mSel == NR - 1) ? 0 : mSel + 1;
    @(posedge clk);
    #1;
    if (expQ.size() == 2) begin
      e = expQ.pop_front();
      checkOutput("sync", {27'd0, o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de}, {27'd0, e.sync});
      checkOutput("rgb", {8'd0, o_sync_red, o_sync_grn, o_sync_blu}, {8'd0, e.rgb});
    end
  endtask

  task automatic driveFrame(int nPix, int nLines, int midLine, int midCnt);
    for (int i = 0; i < 3; i++) begin setSync(1, 0, 0, 0, 0); applyStimulus(); end
    for (int i = 0; i < 2; i++) begin setSync(0, 0, 0, 0, 0); applyStimulus(); end
    for (int ln = 0; ln < nLines; ln++) begin
      for (int p = 0; p < nPix; p++) begin
        setSync(0, 0, 1, 1, 1);
        curPix = p; curLine = ln;
        if (ln == midLine && p < midCnt) i_pls_e = 1;
        applyStimulus();
        i_pls_e = 0;
      end
      for (int b = 0; b < 4; b++) begin
        setSync(0, (b == 1 || b == 2), 1, 0, 0);
        applyStimulus();
      end
    end
    for (int i = 0; i < 2; i++) begin setSync(0, 0, 0, 0, 0); applyStimulus(); end
  endtask

  task automatic checkAllZero(string name);
    checkOutput(name, {23'd0, o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de,
                       o_sync_red, o_sync_grn, o_sync_blu}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, expected completion before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Rows: c, e, w, s, n, mouse_valid, dx, dy, expected o_sel
    vecs.push_back(mkVec(0,0,1,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(0,0,1,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(0,0,1,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(0,0,1,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(0,1,1,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(0,0,0,0,1,1, 9'd0,   9'h1FB, 2'd0));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd1));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd2));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd3));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd0));
    vecs.push_back(mkVec(1,0,0,1,0,0, 9'd0,   9'd0,   2'd1));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd2));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd3));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(0,0,0,0,0,1, 9'h0FF, 9'd0, 2'd0));
    vecs.push_back(mkVec(0,0,0,0,0,1, 9'd100, 9'd0,   2'd0));
    vecs.push_back(mkVec(0,1,0,0,0,1, 9'h138, 9'd0,   2'd0));
    vecs.push_back(mkVec(0,0,0,0,0,1, 9'd0,   9'd3,   2'd0));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd1));
    vecs.push_back(mkVec(1,0,0,0,0,0, 9'd0,   9'd0,   2'd2));

    curPix = 0; curLine = 0;
    clearPulses();
    setSync(1, 1, 1, 1, 1);
    rst_n = 1'b0;
    resetModel();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkAllZero("reset_outputs");
      checkOutput("reset_sel", {30'd0, o_sel}, 32'd0);
    end
    setSync(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] frame A: reset positions, three E pulses mid-frame");
    driveFrame(128, 90, 2, 3);
    $display("[TB] frame B: rect0 moved to x=24, overlapping rect1");
    driveFrame(128, 90, -1, 0);

    $display("[TB] edit vectors between frames");
    setSync(0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      i_pls_c = vecs[i].c; i_pls_e = vecs[i].e; i_pls_w = vecs[i].w;
      i_pls_s = vecs[i].s; i_pls_n = vecs[i].n; i_mouse_valid = vecs[i].mv;
      i_mouse_dif_x = vecs[i].dx; i_mouse_dif_y = vecs[i].dy;
      applyStimulus();
      clearPulses();
      checkOutput("sel", {30'd0, o_sel}, {30'd0, vecs[i].expSel});
    end

    $display("[TB] frame C: full-width lines, rect0 clamped at the right edge");
    driveFrame(1280, 22, -1, 0);

    $display("[TB] reset asserted mid-line");
    for (int p = 0; p < 10; p++) begin
      setSync(0, 0, 1, 1, 1);
      curPix = p; curLine = 0;
      applyStimulus();
    end
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midreset_outputs");
    checkOutput("midreset_sel", {30'd0, o_sel}, 32'd0);
    resetModel();
    setSync(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkAllZero("midreset_hold");
    end
    rst_n = 1'b1;

    $display("[TB] frame D: positions back at reset values");
    driveFrame(128, 20, -1, 0);
    checkOutput("final_sel", {30'd0, o_sel}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
